// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_ADC = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9
  } op_t;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  // Bit positions inside the four-bit flag register.
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/control inputs and result/bus outputs of the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   op;
  logic         start;
  logic         fi_;
  logic         eo_;
  logic [N-1:0] led;
  logic [N-1:0] hi;
  logic [N-1:0] bus;
  logic         cf;
  logic         zf;
  logic         nf;
  logic         vf;
  logic         busy;
  logic         done;

  modport master (
    output a, b, op, start, fi_, eo_,
    input  led, hi, bus, cf, zf, nf, vf, busy, done
  );

  modport slave (
    input  a, b, op, start, fi_, eo_,
    output led, hi, bus, cf, zf, nf, vf, busy, done
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per step.
module alu_mul_iter #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           clr_,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   mcand_in,
  input  logic [N-1:0]   mplier_in,
  output logic [2*N-1:0] prod_nxt,
  output logic           last
);
  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]   mcand;
  logic [2*N-1:0] p;
  logic [CW-1:0]  cnt;
  logic [N:0]     upper;

  // Upper half accumulates the multiplicand when the current multiplier bit
  // (p[0]) is set; the whole register then shifts right one place.
  always_comb begin
    upper    = {1'b0, p[2*N-1:N]} + {1'b0, (p[0] ? mcand : {N{1'b0}})};
    prod_nxt = {upper, p[N-1:1]};
    last     = step && (cnt == CW'(N-1));
  end

  // Operand capture on load, one iteration per step.
  always_ff @(posedge clk) begin
    if (!clr_) begin
      mcand <= '0;
      p     <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= mcand_in;
      p     <= {{N{1'b0}}, mplier_in};
      cnt   <= '0;
    end else if (step) begin
      p   <= prod_nxt;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with flag register, sliced ripple adder and iterative MUL.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned SIZE_283 = 4,
  parameter bit          MUL_EN   = 1'b1
) (
  input  logic      clk,
  input  logic      clr_,
  alu_seq_if.slave  io
);
  localparam int unsigned NSLICE = N / SIZE_283;

  if (N < 4 || (N % SIZE_283) != 0) begin : g_bad_width
    $error("alu_seq: N must be >= 4 and a multiple of SIZE_283");
  end

  state_t         state;
  logic [N-1:0]   led_q;
  logic [N-1:0]   hi_q;
  logic [3:0]     flags;
  logic           busy_q;
  logic           done_q;
  logic           mul_fi_;

  op_t            opc;
  logic           is_mul;
  logic           sub_op;
  logic           cin;
  logic [N-1:0]   b_add;
  logic [N-1:0]   sum;
  logic           carry;
  logic           add_co;
  logic [N-1:0]   res;
  logic           res_cf;
  logic           res_vf;
  logic [3:0]     alu_flags;
  logic [3:0]     mul_flags;

  logic           mul_load;
  logic           mul_step;
  logic [2*N-1:0] prod;
  logic           mul_last;

  assign opc      = op_t'(io.op);
  assign is_mul   = MUL_EN && (opc == OP_MUL);
  assign mul_load = (state == IDLE) && io.start && is_mul;
  assign mul_step = (state == MUL_RUN);

  // Ripple adder built from SIZE_283-bit slices; subtraction inverts B.
  always_comb begin
    sub_op = (opc == OP_SUB) || (opc == OP_SBC);
    case (opc)
      OP_SUB:         cin = 1'b1;
      OP_ADC, OP_SBC: cin = flags[FLAG_C];
      default:        cin = 1'b0;
    endcase
    b_add = sub_op ? ~io.b : io.b;
    sum   = '0;
    carry = cin;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      {carry, sum[s*SIZE_283 +: SIZE_283]} =
        {1'b0, io.a[s*SIZE_283 +: SIZE_283]} +
        {1'b0, b_add[s*SIZE_283 +: SIZE_283]} +
        (SIZE_283+1)'(carry);
    end
    add_co = carry;
  end

  // Single-cycle result, carry and overflow selection.
  always_comb begin
    res    = io.a;
    res_cf = 1'b0;
    res_vf = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        res    = sum;
        res_cf = add_co;
        res_vf = (io.a[N-1] == b_add[N-1]) && (sum[N-1] != io.a[N-1]);
      end
      OP_AND: begin res = io.a & io.b; res_cf = add_co; end
      OP_OR:  begin res = io.a | io.b; res_cf = add_co; end
      OP_XOR: begin res = io.a ^ io.b; res_cf = add_co; end
      OP_SHL: begin res = {io.a[N-2:0], 1'b0}; res_cf = io.a[N-1]; end
      OP_SHR: begin res = {1'b0, io.a[N-1:1]}; res_cf = io.a[0]; end
      default: begin res = io.a; res_cf = 1'b0; end
    endcase
  end

  // Candidate flag words for single-cycle ops and for the MUL completion.
  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = res_cf;
    alu_flags[FLAG_Z] = (res == '0);
    alu_flags[FLAG_N] = res[N-1];
    alu_flags[FLAG_V] = res_vf;
    mul_flags         = '0;
    mul_flags[FLAG_C] = (prod[2*N-1:N] != '0);
    mul_flags[FLAG_Z] = (prod == '0);
    mul_flags[FLAG_N] = prod[N-1];
    mul_flags[FLAG_V] = (prod[2*N-1:N] != '0);
  end

  alu_mul_iter #(.N(N)) u_mul (
    .clk       (clk),
    .clr_      (clr_),
    .load      (mul_load),
    .step      (mul_step),
    .mcand_in  (io.a),
    .mplier_in (io.b),
    .prod_nxt  (prod),
    .last      (mul_last)
  );

  // Control FSM plus result/flag registers; start is only seen in IDLE.
  always_ff @(posedge clk) begin
    if (!clr_) begin
      state   <= IDLE;
      led_q   <= '0;
      hi_q    <= '0;
      flags   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mul_fi_ <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            if (is_mul) begin
              state   <= MUL_RUN;
              busy_q  <= 1'b1;
              mul_fi_ <= io.fi_;
            end else begin
              led_q  <= res;
              hi_q   <= '0;
              done_q <= 1'b1;
              if (!io.fi_) flags <= alu_flags;
            end
          end
        end
        MUL_RUN: begin
          if (mul_last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            led_q  <= prod[N-1:0];
            hi_q   <= prod[2*N-1:N];
            if (!mul_fi_) flags <= mul_flags;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.led  = led_q;
  assign io.hi   = hi_q;
  assign io.bus  = io.eo_ ? {N{1'bz}} : led_q;
  assign io.cf   = flags[FLAG_C];
  assign io.zf   = flags[FLAG_Z];
  assign io.nf   = flags[FLAG_N];
  assign io.vf   = flags[FLAG_V];
  assign io.busy = busy_q;
  assign io.done = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at N=8.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic clr_;
  int   n_cmp;
  int   n_err;

  alu_seq_if #(.N(8)) io ();

  alu_seq #(.N(8), .SIZE_283(4), .MUL_EN(1'b1)) dut (
    .clk  (clk),
    .clr_ (clr_),
    .io   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns #1 after the launch edge.
  task automatic launch(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic fi);
    @(negedge clk);
    io.op    = op;
    io.a     = a;
    io.b     = b;
    io.fi_   = fi;
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
  endtask

  // Step edges until busy drops (bounded); optional ignored start at inj.
  task automatic wait_mul(input int inj, output int cyc, output logic [7:0] led_mid);
    cyc     = 0;
    led_mid = 8'hxx;
    while (io.busy && cyc < 20) begin
      @(negedge clk);
      if (cyc == inj) begin
        io.start = 1'b1;
        io.op    = OP_ADD;
        io.a     = 8'h01;
        io.b     = 8'h01;
      end else begin
        io.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 4) led_mid = io.led;
    end
    io.start = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [7:0]  mid;
    logic        saw;
    n_cmp    = 0;
    n_err    = 0;
    clr_     = 1'b0;
    io.start = 1'b0;
    io.eo_   = 1'b1;
    io.fi_   = 1'b1;
    io.op    = 4'd0;
    io.a     = 8'h00;
    io.b     = 8'h00;

    // 1: reset
    @(posedge clk);
    #1;
    clr_ = 1'b1;
    check("rst_led", io.led, 8'h00);
    check("rst_hi", io.hi, 8'h00);
    check("rst_flags", {io.vf, io.nf, io.zf, io.cf}, 4'b0000);
    check("rst_busy", io.busy, 1'b0);
    check("rst_done", io.done, 1'b0);
    io.eo_ = 1'b0;
    #1;
    check("rst_bus", io.bus, 8'h00);

    // 2: ADD with carry out to zero
    launch(OP_ADD, 8'hFF, 8'h01, 1'b0);
    check("add_led", io.led, 8'h00);
    check("add_flags", {io.vf, io.nf, io.zf, io.cf}, 4'b0011);
    check("add_done", io.done, 1'b1);
    @(posedge clk);
    #1;
    check("add_done_drop", io.done, 1'b0);

    // 3: SUB with borrow, then SBC consuming it
    launch(OP_SUB, 8'h05, 8'h07, 1'b0);
    check("sub_led", io.led, 8'hFE);
    check("sub_cf_nf", {io.nf, io.cf}, 2'b10);
    check("sub_bus", io.bus, 8'hFE);
    launch(OP_SBC, 8'h10, 8'h01, 1'b0);
    check("sbc_led", io.led, 8'h0E);
    check("sbc_cf", io.cf, 1'b1);

    // 4: signed overflow, then flag hold with fi_=1
    launch(OP_ADD, 8'h7F, 8'h01, 1'b0);
    check("ovf_led", io.led, 8'h80);
    check("ovf_flags", {io.vf, io.nf, io.zf, io.cf}, 4'b1100);
    launch(OP_ADD, 8'h01, 8'h01, 1'b1);
    check("hold_led", io.led, 8'h02);
    check("hold_flags", {io.vf, io.nf, io.zf, io.cf}, 4'b1100);

    // logic, shifts, reserved opcode
    launch(OP_AND, 8'hF0, 8'h3C, 1'b0);
    check("and_led", io.led, 8'h30);
    check("and_vzn", {io.vf, io.nf, io.zf}, 3'b000);
    launch(OP_XOR, 8'hAA, 8'hAA, 1'b0);
    check("xor_led", io.led, 8'h00);
    check("xor_zf", io.zf, 1'b1);
    launch(OP_OR, 8'h81, 8'h02, 1'b0);
    check("or_led", io.led, 8'h83);
    launch(OP_SHL, 8'h81, 8'h00, 1'b0);
    check("shl_led", io.led, 8'h02);
    check("shl_cf", io.cf, 1'b1);
    launch(OP_SHR, 8'h01, 8'h00, 1'b0);
    check("shr_led", io.led, 8'h00);
    check("shr_cz", {io.zf, io.cf}, 2'b11);
    launch(4'hF, 8'h5A, 8'h33, 1'b0);
    check("rsv_led", io.led, 8'h5A);
    check("rsv_flags", {io.vf, io.nf, io.zf, io.cf}, 4'b0000);

    // 5: MUL 0x0F*0x11 with an ignored mid-run start
    launch(OP_MUL, 8'h0F, 8'h11, 1'b0);
    check("mul1_busy", io.busy, 1'b1);
    check("mul1_done_lo", io.done, 1'b0);
    wait_mul(3, cyc, mid);
    check("mul1_cycles", cyc, 8);
    check("mul1_led_hold", mid, 8'h5A);
    check("mul1_done", io.done, 1'b1);
    check("mul1_led", io.led, 8'hFF);
    check("mul1_hi", io.hi, 8'h00);
    check("mul1_flags", {io.vf, io.nf, io.zf, io.cf}, 4'b0100);
    @(posedge clk);
    #1;
    check("mul1_done_drop", io.done, 1'b0);
    check("mul1_no_queue", io.led, 8'hFF);

    launch(OP_MUL, 8'hFF, 8'hFF, 1'b0);
    wait_mul(-1, cyc, mid);
    check("mul2_cycles", cyc, 8);
    check("mul2_prod", {io.hi, io.led}, 16'hFE01);
    check("mul2_flags", {io.vf, io.nf, io.zf, io.cf}, 4'b1001);

    // 6: clear during MUL iteration 4
    launch(OP_MUL, 8'h03, 8'h05, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_ = 1'b0;
    @(posedge clk);
    #1;
    clr_ = 1'b1;
    check("abort_busy", io.busy, 1'b0);
    check("abort_done", io.done, 1'b0);
    check("abort_res", {io.hi, io.led}, 16'h0000);
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (io.done || io.busy) saw = 1'b1;
    end
    check("abort_quiet", saw, 1'b0);
    launch(OP_ADD, 8'h02, 8'h03, 1'b0);
    check("post_led", io.led, 8'h05);
    check("post_done", io.done, 1'b1);
    check("post_bus", io.bus, 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation ALU for the breadboard-style CPU, parametrised in width.
- Registers its result and latches a four-bit flag register (CF, ZF, NF, VF).
- Adds logic, shift, carry-chained add/subtract and an iterative shift-add multiplier.
- Sits between the A/B registers and the shared bus; drives the bus through an active-low output enable.

Parameters:
- N, 8, datapath width in bits; must be ≥ 4 and a multiple of SIZE_283.
- SIZE_283, 4, adder slice width; the carry ripples between slices.
- MUL_EN, 1, when 0 the MUL opcode behaves as reserved.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr_  in  1  synchronous active-low reset.
- a  in  N  operand A.
- b  in  N  operand B.
- op  in  4  operation code; encodings are in alu_pkg.
- start  in  1  launches the operation when high and not busy.
- fi_  in  1  flags-in enable, active low; sampled together with start.
- eo_  in  1  bus output enable, active low.
- led  out  N  result register; always driven, for the display.
- hi  out  N  high half of the last MUL product; 0 after any other op.
- bus  out  N  result register when eo_=0, high-Z otherwise.
- cf, zf, nf, vf  out  1 each  flag register outputs.
- busy  out  1  a MUL is in progress.
- done  out  1  one-cycle pulse when the result register updates.

Behaviour:
- Reset (clr_=0 at an edge):
  - led, hi, all flags, busy and done go to 0.
  - An in-progress MUL is aborted with no done pulse.
  - clr_ takes priority over start.
- Bus output is combinational from the result register and eo_, independent of busy.
- Launch: start=1 with busy=0 samples a, b, op and fi_. start while busy=1 is ignored; no queueing.
- Single-cycle ops (latency 1):
  - On the launch edge the result goes to led, hi goes to 0, and done=1 for the following cycle.
- Operations (c = cf register value before the launch):
  - ADD: a+b.
  - SUB: a+~b+1.
  - ADC: a+b+c.
  - SBC: a+~b+c. Carry is 6502-style, so cf=1 means no borrow.
  - AND, OR, XOR: bitwise.
  - SHL: a<<1, cf=a[N-1].
  - SHR: logical a>>1, cf=a[0].
  - Reserved opcodes: result=a, cf=0.
- Flags: latched only when fi_=0 at the launch; otherwise all four flags hold.
  - zf = (result==0).
  - nf = result[N-1].
  - cf = adder carry-out of the top slice.
  - vf = signed overflow for ADD/ADC/SUB/SBC, 0 for every other op.
- MUL (unsigned, N x N gives 2N bits):
  - Launch edge: capture operands, clear the accumulator, busy=1.
  - Then exactly N iteration edges, one multiplier bit per edge.
  - On the Nth iteration edge: {hi,led} = product, busy=0, done=1 in the next cycle.
  - Total latency is N+1 edges from launch.
  - MUL flags: zf = whole 2N-bit product is zero; nf = led[N-1]; cf = vf = (hi!=0).
  - led, hi and the flags are not modified while busy.
- State machine: IDLE -> (start & op==MUL) -> MUL_RUN (counter 0..N-1) -> IDLE.
  - Every other launch stays in IDLE.
  - clr_=0 returns to IDLE from any state.

Decomposition:
- alu_pkg holds:
  - the op_t enum: ADD=0, SUB=1, ADC=2, SBC=3, AND=4, OR=5, XOR=6, SHL=7, SHR=8, MUL=9, 10–15 reserved;
  - the state_t enum {IDLE, MUL_RUN};
  - the flag-index constants.
- Sub-module alu_mul_iter: shift-add core with its iteration counter, driven by a load/step handshake.

Test Plan (N=8):
1. clr_=0 for one edge with eo_=1 -> led=0x00, hi=0x00, all flags 0, busy=0, done=0, bus=Z. Then eo_=0 -> bus=0x00.
2. ADD 0xFF+0x01, fi_=0, one start pulse -> next cycle led=0x00, cf=1, zf=1, nf=0, vf=0, done high for exactly one cycle.
3. SUB 0x05-0x07 -> led=0xFE, cf=0, nf=1. Then SBC 0x10-0x01 using that cf=0 -> led=0x0E, cf=1.
4. ADD 0x7F+0x01 -> led=0x80, vf=1, nf=1. Then ADD 0x01+0x01 with fi_=1 -> led=0x02, flags still vf=1, nf=1.
5. MUL 0x0F*0x11 -> busy=1 for 8 cycles, done after edge 9, led=0xFF, hi=0x00, cf=0.
   - MUL 0xFF*0xFF -> hi=0xFE, led=0x01, cf=1, vf=1.
   - A second start issued mid-run is ignored.
6. MUL started, then clr_=0 at iteration 4 -> busy=0, done never pulses, led=hi=0x00. A following ADD 0x02+0x03 -> led=0x05 after 1 cycle.
